// File: rtl/lottery_pkg.sv
// Shared definitions for the weighted lottery arbiter.
//   - FSM state encoding
//   - requester count
//   - maximal-length Fibonacci LFSR tap table and the default LFSR width
//   - small helper to find the lowest set bit of a request vector
package lottery_pkg;

    localparam int NUM_REQ = 4;

    // Default LFSR width matches the default weight width (WIDTH=7 -> WIDTH+3).
    localparam int LFSR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    // Tap masks for maximal-length Fibonacci LFSRs. Bit (n-1) set means
    // tap n of the polynomial participates in the feedback XOR.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return 32'h0000_0000;
        endcase
    endfunction

    localparam logic [31:0] LFSR_TAPS = lfsr_taps(LFSR_W);

    function automatic logic [1:0] lowest_index(input logic [NUM_REQ-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lottery_lfsr.sv
// Fibonacci LFSR used as the lottery random source.
// Ports:
//   in_clock   rising-edge clock
//   in_load    synchronous load of in_seed (zero seed loads 1)
//   in_seed    seed value
//   in_enable  advance one step this cycle
//   out_state  current LFSR state
module lottery_lfsr
    import lottery_pkg::*;
#(
    parameter int W = LFSR_W
) (
    input  logic         in_clock,
    input  logic         in_load,
    input  logic [W-1:0] in_seed,
    input  logic         in_enable,
    output logic [W-1:0] out_state
);

    localparam logic [31:0]  TAPS_FULL = lfsr_taps(W);
    localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];

    if (TAPS_FULL == 32'h0) begin : g_bad_width
        $error("lottery_lfsr: no tap table entry for this width");
    end

    logic [W-1:0] r_state;
    logic         w_feedback;

    assign w_feedback = ^(r_state & TAPS);

    always_ff @(posedge in_clock) begin
        if (in_load) begin
            // An all-zero state would lock the LFSR up.
            r_state <= (in_seed == '0) ? {{(W-1){1'b0}}, 1'b1} : in_seed;
        end else if (in_enable) begin
            r_state <= {r_state[W-2:0], w_feedback};
        end
    end

    assign out_state = r_state;

endmodule

// File: rtl/weighted_lottery_arbiter.sv
// Four-requester weighted lottery arbiter.
// A requester is eligible when it requests with a non-zero weight. In IDLE the
// eligible weights are snapshotted; DRAW pulls LFSR values (rejection sampling
// against the weight sum) until one lands inside the sum, or falls back to the
// lowest eligible requester after MAX_RETRY rejects. GRANT holds until the
// granted requester drops its request.
//
// Optional build macro: LOTTERY_STARVE_GUARD_EN adds per-requester wait
// counters; a requester that lost STARVE_LIMIT or more draws is granted
// directly without consuming an LFSR value.
//
// Ports:
//   in_clock           rising-edge clock
//   in_reset           synchronous active-high reset (also loads in_seed)
//   in_seed            LFSR seed
//   in_request[3:0]    request per requester
//   in_weight0..3      weight per requester
//   out_grant[3:0]     one-hot grant or zero
//   out_grant_valid    grant held
//   out_grant_index    granted index, 0 when no grant
//   out_busy           FSM not in IDLE
module weighted_lottery_arbiter
    import lottery_pkg::*;
#(
    parameter int WIDTH        = 7,
    parameter int MAX_RETRY    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               in_clock,
    input  logic               in_reset,
    input  logic [WIDTH+2:0]   in_seed,
    input  logic [NUM_REQ-1:0] in_request,
    input  logic [WIDTH:0]     in_weight0,
    input  logic [WIDTH:0]     in_weight1,
    input  logic [WIDTH:0]     in_weight2,
    input  logic [WIDTH:0]     in_weight3,
    output logic [NUM_REQ-1:0] out_grant,
    output logic               out_grant_valid,
    output logic [1:0]         out_grant_index,
    output logic               out_busy
);

    localparam int SUM_W   = WIDTH + 3;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    if (MAX_RETRY < 1 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("weighted_lottery_arbiter: MAX_RETRY and STARVE_LIMIT must be >= 1");
    end

    state_t             r_state;
    logic [WIDTH:0]     r_weight [NUM_REQ];
    logic [SUM_W-1:0]   r_sum;
    logic [SUM_W-1:0]   r_mask;
    logic [NUM_REQ-1:0] r_elig;
    logic [RETRY_W-1:0] r_retry;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_grant_valid;
    logic [1:0]         r_grant_index;

    logic [WIDTH:0]     w_weight_in [NUM_REQ];
    logic [NUM_REQ-1:0] w_eligible;
    logic [SUM_W-1:0]   w_sum_in;
    logic [SUM_W-1:0]   w_mask_in;
    logic [SUM_W-1:0]   w_lfsr;
    logic [SUM_W-1:0]   w_candidate;
    logic [SUM_W-1:0]   w_rem;
    logic               w_found;
    logic [1:0]         w_pick_index;
    logic               w_accept;
    logic               w_fallback;
    logic               w_force;
    logic               w_done;
    logic [1:0]         w_sel_index;
    logic               w_lfsr_en;

    assign w_weight_in[0] = in_weight0;
    assign w_weight_in[1] = in_weight1;
    assign w_weight_in[2] = in_weight2;
    assign w_weight_in[3] = in_weight3;

    // Eligibility, masked sum and the rejection-sampling mask (sum-1 with all
    // bits below its leading one filled in).
    always_comb begin
        w_eligible = '0;
        w_sum_in   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = in_request[i] && (w_weight_in[i] != '0);
            if (w_eligible[i]) w_sum_in = w_sum_in + SUM_W'(w_weight_in[i]);
        end
        w_mask_in = w_sum_in - SUM_W'(1);
        for (int i = 0; i < SUM_W; i++) begin
            w_mask_in = w_mask_in | (w_mask_in >> 1);
        end
    end

`ifdef LOTTERY_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0]  r_wait [NUM_REQ];
    logic               r_starve;
    logic [1:0]         r_starve_index;
    logic [NUM_REQ-1:0] w_starved;

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_starved[i] = w_eligible[i] && (r_wait[i] >= WAIT_W'(STARVE_LIMIT));
        end
    end

    assign w_force = r_starve;
`else
    assign w_force = 1'b0;
`endif

    assign w_candidate = w_lfsr & r_mask;
    assign w_accept    = (w_candidate < r_sum);
    assign w_fallback  = (r_retry == RETRY_W'(MAX_RETRY));

    // Cumulative subtraction: first requester whose weight exceeds the
    // remainder wins. Masked-out weights are zero and can never win.
    always_comb begin
        w_rem        = w_candidate;
        w_found      = 1'b0;
        w_pick_index = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found) begin
                if (w_rem < SUM_W'(r_weight[i])) begin
                    w_pick_index = 2'(i);
                    w_found      = 1'b1;
                end else begin
                    w_rem = w_rem - SUM_W'(r_weight[i]);
                end
            end
        end
    end

    always_comb begin
        w_sel_index = w_pick_index;
        w_done      = w_accept;
`ifdef LOTTERY_STARVE_GUARD_EN
        if (r_starve) begin
            w_sel_index = r_starve_index;
            w_done      = 1'b1;
        end else
`endif
        if (w_fallback) begin
            w_sel_index = lowest_index(r_elig);
            w_done      = 1'b1;
        end
    end

    assign w_lfsr_en = (r_state == ST_DRAW) && !w_force;

    lottery_lfsr #(
        .W (SUM_W)
    ) u_lfsr (
        .in_clock  (in_clock),
        .in_load   (in_reset),
        .in_seed   (in_seed),
        .in_enable (w_lfsr_en),
        .out_state (w_lfsr)
    );

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_state       <= ST_IDLE;
            r_sum         <= '0;
            r_mask        <= '0;
            r_elig        <= '0;
            r_retry       <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_index <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_weight[i] <= '0;
`ifdef LOTTERY_STARVE_GUARD_EN
            r_starve       <= 1'b0;
            r_starve_index <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_eligible) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            r_weight[i] <= w_eligible[i] ? w_weight_in[i] : '0;
                        end
                        r_sum   <= w_sum_in;
                        r_mask  <= w_mask_in;
                        r_elig  <= w_eligible;
                        r_retry <= '0;
`ifdef LOTTERY_STARVE_GUARD_EN
                        r_starve       <= |w_starved;
                        r_starve_index <= lowest_index(w_starved);
`endif
                        r_state <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (w_done) begin
                        r_grant       <= NUM_REQ'(1) << w_sel_index;
                        r_grant_valid <= 1'b1;
                        r_grant_index <= w_sel_index;
                        r_state       <= ST_GRANT;
`ifdef LOTTERY_STARVE_GUARD_EN
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (2'(i) == w_sel_index) begin
                                r_wait[i] <= '0;
                            end else if (r_elig[i] && r_wait[i] != WAIT_W'(STARVE_LIMIT)) begin
                                r_wait[i] <= r_wait[i] + WAIT_W'(1);
                            end
                        end
`endif
                    end else begin
                        r_retry <= r_retry + RETRY_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (!in_request[r_grant_index]) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_grant_index <= '0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_grant       = r_grant;
    assign out_grant_valid = r_grant_valid;
    assign out_grant_index = r_grant_index;
    assign out_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_weighted_lottery_arbiter.sv
// Self-checking bench for weighted_lottery_arbiter (default parameters).
// The reference model predicts each transaction's winner and grant latency
// from the lottery rules using plain integer arithmetic.
module tb_weighted_lottery_arbiter;

    localparam int WIDTH        = 7;
    localparam int MAX_RETRY    = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int SW           = WIDTH + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] seed;
    logic [3:0]    req;
    logic [7:0]    w0, w1, w2, w3;
    logic [3:0]    grant;
    logic          valid;
    logic [1:0]    gidx;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned m_lfsr;
    int          m_wait [4];

    always #5 clk = ~clk;

    weighted_lottery_arbiter #(
        .WIDTH        (WIDTH),
        .MAX_RETRY    (MAX_RETRY),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .in_clock        (clk),
        .in_reset        (rst),
        .in_seed         (seed),
        .in_request      (req),
        .in_weight0      (w0),
        .in_weight1      (w1),
        .in_weight2      (w2),
        .in_weight3      (w3),
        .out_grant       (grant),
        .out_grant_valid (valid),
        .out_grant_index (gidx),
        .out_busy        (busy)
    );

    typedef struct {
        logic [3:0][7:0] w;
        logic [3:0]      r;
        int              exp_idx;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic tick();
        int enc;
        @(posedge clk);
        #1;
        enc = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) enc = i;
        chk("valid_vs_grant", int'(valid), int'(|grant));
        chk("grant_onehot0", int'($onehot0(grant)), 1);
        chk("index_vs_grant", int'(gidx), valid ? enc : 0);
    endtask

    function automatic logic [3:0][7:0] mkw(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] w;
        w[0] = 8'(a);
        w[1] = 8'(b);
        w[2] = 8'(c);
        w[3] = 8'(d);
        return w;
    endfunction

    function automatic int unsigned lfsr_next(input int unsigned s);
        int unsigned fb;
        fb = ((s >> 9) ^ (s >> 6)) & 1;
        return ((s << 1) | fb) & 32'h3FF;
    endfunction

    // Predict winner (-1 when nobody is eligible) and cycles from driving the
    // request until the grant is visible.
    task automatic predict(input logic [3:0][7:0] w, input logic [3:0] r,
                           output int idx, output int lat);
        int wm [4];
        int sum, m, acc, low;
        int unsigned draw;
        bit forced, got;
        sum = 0; low = -1; forced = 0; idx = -1; lat = 0;
        for (int i = 0; i < 4; i++) begin
            wm[i] = (r[i] && w[i] != 0) ? int'(w[i]) : 0;
            sum += wm[i];
            if (wm[i] != 0 && low < 0) low = i;
        end
        if (sum == 0) return;
`ifdef LOTTERY_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            if (!forced && wm[i] != 0 && m_wait[i] >= STARVE_LIMIT) begin
                idx = i; lat = 2; forced = 1;
            end
        end
`endif
        if (!forced) begin
            m = 0;
            while (m + 1 < sum) m = m * 2 + 1;
            got = 0;
            for (int k = 0; k <= MAX_RETRY && !got; k++) begin
                if (k == MAX_RETRY) begin
                    idx = low;
                    m_lfsr = lfsr_next(m_lfsr);
                    lat = 2 + k;
                    got = 1;
                end else begin
                    draw = m_lfsr & m;
                    m_lfsr = lfsr_next(m_lfsr);
                    if (draw < sum) begin
                        acc = 0;
                        for (int i = 0; i < 4 && idx < 0; i++) begin
                            acc += wm[i];
                            if (int'(draw) < acc) idx = i;
                        end
                        lat = 2 + k;
                        got = 1;
                    end
                end
            end
        end
`ifdef LOTTERY_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            if (i == idx) m_wait[i] = 0;
            else if (wm[i] != 0) m_wait[i]++;
        end
`endif
    endtask

    task automatic do_reset(input logic [SW-1:0] s);
        rst = 1'b1; seed = s; req = '0;
        tick();
        chk("reset_grant", int'(grant), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_index", int'(gidx), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;
        m_lfsr = (s == '0) ? 1 : int'(s);
        for (int i = 0; i < 4; i++) m_wait[i] = 0;
    endtask

    task automatic run_txn(input logic [3:0][7:0] w, input logic [3:0] r,
                           input int hold, input bit perturb, output int got);
        int e_idx, e_lat, n;
        predict(w, r, e_idx, e_lat);
        w0 = w[0]; w1 = w[1]; w2 = w[2]; w3 = w[3];
        req = r;
        if (e_idx < 0) begin
            repeat (4) tick();
            chk("idle_busy", int'(busy), 0);
            chk("idle_grant", int'(grant), 0);
            got = valid ? int'(gidx) : -1;
            req = '0;
            return;
        end
        tick();
        n = 1;
        chk("busy_in_draw", int'(busy), 1);
        if (perturb) begin
            w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
        end
        while (!valid && n < 12) begin
            tick();
            n++;
        end
        chk("grant_latency", n, e_lat);
        chk("grant_index", int'(gidx), e_idx);
        chk("grant_vector", int'(grant), 1 << e_idx);
        got = int'(gidx);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_vector", int'(grant), 1 << e_idx);
            chk("hold_valid", int'(valid), 1);
        end
        req = '0;
        tick();
        chk("release_grant", int'(grant), 0);
        chk("release_busy", int'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        int   got, e_idx, e_lat;
        int   cnt [4];
        logic [3:0][7:0] rw;

        vecs[0] = '{mkw(0, 0, 5, 0),         4'b1111,  2};
        vecs[1] = '{mkw(0, 0, 9, 9),         4'b0011, -1};
        vecs[2] = '{mkw(7, 0, 0, 0),         4'b0001,  0};
        vecs[3] = '{mkw(3, 0, 0, 0),         4'b1110, -1};
        vecs[4] = '{mkw(0, 9, 0, 0),         4'b0011,  1};
        vecs[5] = '{mkw(0, 0, 0, 255),       4'b1000,  3};
        vecs[6] = '{mkw(255, 255, 255, 255), 4'b0000, -1};
        vecs[7] = '{mkw(0, 0, 5, 0),         4'b1111,  2};
        vecs[8] = '{mkw(0, 1, 0, 0),         4'b1111,  1};

        rst = 1'b1; seed = '0; req = '0; w0 = '0; w1 = '0; w2 = '0; w3 = '0;
        do_reset(10'h155);

        for (int v = 0; v < 9; v++) begin
            run_txn(vecs[v].w, vecs[v].r, v % 3, 1'b0, got);
            chk($sformatf("vec%0d_index", v), got, vecs[v].exp_idx);
        end

        // Long hold then release.
        run_txn(mkw(0, 6, 0, 0), 4'b0010, 10, 1'b0, got);
        chk("hold10_index", got, 1);

        // Request dropped while drawing: one-cycle grant.
        predict(mkw(0, 4, 0, 0), 4'b0010, e_idx, e_lat);
        w0 = 0; w1 = 4; w2 = 0; w3 = 0; req = 4'b0010;
        tick();
        req = '0;
        tick();
        chk("drop_grant", int'(grant), 4'b0010);
        chk("drop_valid", int'(valid), 1);
        tick();
        chk("drop_release", int'(grant), 0);
        chk("drop_busy", int'(busy), 0);

        // Reset while in DRAW.
        w0 = 1; w1 = 1; w2 = 1; w3 = 5; req = 4'b1111;
        tick();
        chk("pre_reset_busy", int'(busy), 1);
        do_reset('0);
        tick();

        // Reset while in GRANT.
        predict(mkw(0, 0, 3, 0), 4'b0100, e_idx, e_lat);
        w0 = 0; w1 = 0; w2 = 3; w3 = 0; req = 4'b0100;
        tick();
        tick();
        chk("pre_reset_grant", int'(grant), 4'b0100);
        do_reset('0);

        // Zero seed must have loaded 1: first draw reads 1 -> index 1.
        run_txn(mkw(1, 1, 1, 5), 4'b1111, 0, 1'b0, got);
        chk("seed0_first_draw", got, 1);

        // Sum just above a power of two: frequent rejects and fallbacks.
        for (int t = 0; t < 40; t++) begin
            run_txn(mkw(129, 128, 0, 0), 4'b0011, 0, 1'b0, got);
        end

        // Random traffic with weights disturbed during DRAW.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 4; i++) begin
                rw[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            run_txn(rw, 4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
        end

`ifndef LOTTERY_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int t = 0; t < 8000; t++) begin
            run_txn(mkw(1, 1, 1, 5), 4'b1111, 0, 1'b0, got);
            if (got >= 0) cnt[got]++;
        end
        chk_range("dist_idx0_permille", cnt[0] * 1000 / 8000, 105, 145);
        chk_range("dist_idx1_permille", cnt[1] * 1000 / 8000, 105, 145);
        chk_range("dist_idx2_permille", cnt[2] * 1000 / 8000, 105, 145);
        chk_range("dist_idx3_permille", cnt[3] * 1000 / 8000, 595, 655);
`else
        begin
            int gap;
            do_reset(10'h2A7);
            gap = 0;
            for (int t = 0; t < 60; t++) begin
                run_txn(mkw(1, 0, 0, 255), 4'b1001, 0, 1'b0, got);
                if (got == 0) gap = 0;
                else gap++;
                chk_range("starve_gap", gap, 0, STARVE_LIMIT);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
